gost89_cfb_stream: RTL and testbench

- Parametrised GOST 28147-89 CFB-s engine: s-bit segments (SEG_W = 8/16/32/64); encrypt or decrypt chosen per segment.
- Wraps one gost89_ecb_encrypt core for keystream generation.
- Valid/ready streaming handshake on input and output, explicit IV load, and output backpressure.
- Sits between the host data path and the key/sbox register bank; successor to the fixed 64-bit CFB encrypt/decrypt pair.

---
 rtl/gost89_cfb_stream.sv | 172 +++++++++++++++++
 tb/tb_gost89_cfb_stream.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost89_cfb_stream.sv
// gost89_cfb_stream: GOST 28147-89 CFB-s stream engine built around an iterative ECB core
//
// gost89_ecb_encrypt (one round per clock, 32 rounds per block):
//   clk, reset      clock, synchronous active-high reset
//   load_data       latch in and start a block; busy rises on the same edge
//   sbox[511:0]     S-box j entry v lives at sbox[64*j + 4*v +: 4], S-box j substitutes nibble j
//   key[255:0]      subkey Ki = key[32*i +: 32]
//   in[63:0]        block, N1 = in[31:0], N2 = in[63:32]
//   out[63:0]       result block, valid once busy has fallen
//   busy            high while rounds are running
//
// gost89_cfb_stream:
//   clk, reset      clock, synchronous active-high reset
//   sbox, key       cipher tables, held stable while busy
//   iv_load, iv     load the feedback register (IDLE, READY or HOLD only)
//   decrypt         mode of the segment accepted this cycle
//   in_valid/in_ready/in_data     input segment handshake
//   out_valid/out_ready/out_data  result segment handshake
//   busy            high in RUN or HOLD
module gost89_ecb_encrypt (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_data,
    input  logic [511:0] sbox,
    input  logic [255:0] key,
    input  logic [63:0]  in,
    output logic [63:0]  out,
    output logic         busy
);
    logic [31:0] n1, n2, sum, sub, f;
    logic [4:0]  cnt;
    logic [2:0]  kidx;
    // rounds 0..23 walk K0..K7 forwards, rounds 24..31 walk K7..K0
    assign kidx = (cnt[4] & cnt[3]) ? ~cnt[2:0] : cnt[2:0];
    assign sum = n1 + key[{kidx, 5'b0} +: 32];
    for (genvar j = 0; j < 8; j++) begin : g_sbox
        localparam logic [2:0] J = 3'(j);
        assign sub[4*j +: 4] = sbox[{J, sum[4*j +: 4], 2'b00} +: 4];
    end
    assign f = {sub[20:0], sub[31:21]};
    // every round swaps halves, so the unswapped final round appears as {n1, n2}
    assign out = {n1, n2};
    always_ff @(posedge clk) begin
        if (reset) begin
            n1 <= '0;
            n2 <= '0;
            cnt <= '0;
            busy <= 1'b0;
        end else if (load_data) begin
            n1 <= in[31:0];
            n2 <= in[63:32];
            cnt <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            n1 <= n2 ^ f;
            n2 <= n1;
            cnt <= cnt + 5'd1;
            busy <= cnt != 5'd31;
        end
    end
endmodule

module gost89_cfb_stream #(
    parameter int SEG_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [511:0]     sbox,
    input  logic [255:0]     key,
    input  logic             iv_load,
    input  logic [63:0]      iv,
    input  logic             decrypt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEG_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEG_W-1:0] out_data,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, READY, START, RUN, HOLD} state_t;
    state_t           state, state_nxt;
    logic [63:0]      g, g_nxt, g_fb, core_out;
    logic [SEG_W-1:0] d, d_nxt, r, c, out_data_nxt;
    logic             m, m_nxt, out_valid_nxt, core_load, core_busy;
    if (SEG_W != 8 && SEG_W != 16 && SEG_W != 32 && SEG_W != 64) begin : g_bad_seg_w
        $error("gost89_cfb_stream: SEG_W must be 8, 16, 32 or 64");
    end
    gost89_ecb_encrypt u_core (
        .clk       (clk),
        .reset     (reset),
        .load_data (core_load),
        .sbox      (sbox),
        .key       (key),
        .in        (g),
        .out       (core_out),
        .busy      (core_busy)
    );
    assign r = core_out[63 -: SEG_W] ^ d;
    // the feedback register always takes ciphertext: the input when decrypting, the result when encrypting
    assign c = m ? d : r;
    if (SEG_W == 64) begin : g_full
        assign g_fb = c;
    end else begin : g_shift
        logic unused_core_lsb;
        assign unused_core_lsb = ^core_out[63-SEG_W:0];
        assign g_fb = {g[63-SEG_W:0], c};
    end
    assign core_load = state == START;
    assign in_ready = state == READY && !iv_load;
    assign busy = state == RUN || state == HOLD;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            g <= '0;
            d <= '0;
            m <= 1'b0;
            out_data <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            g <= g_nxt;
            d <= d_nxt;
            m <= m_nxt;
            out_data <= out_data_nxt;
            out_valid <= out_valid_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        g_nxt = g;
        d_nxt = d;
        m_nxt = m;
        out_data_nxt = out_data;
        out_valid_nxt = out_valid;
        case (state)
            IDLE: begin
                if (iv_load) begin
                    g_nxt = iv;
                    state_nxt = READY;
                end
            end
            READY: begin
                if (iv_load) begin
                    g_nxt = iv;
                end else if (in_valid) begin
                    d_nxt = in_data;
                    m_nxt = decrypt;
                    state_nxt = START;
                end
            end
            START: state_nxt = RUN;
            RUN: begin
                if (!core_busy) begin
                    out_data_nxt = r;
                    out_valid_nxt = 1'b1;
                    g_nxt = g_fb;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // an IV load here discards the held result
                if (iv_load || out_ready) begin
                    out_valid_nxt = 1'b0;
                    g_nxt = iv_load ? iv : g;
                    state_nxt = READY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gost89_cfb_stream.sv
// tb_gost89_cfb_stream: scoreboard bench for gost89_cfb_stream at SEG_W = 64 (a), 8 (b) and 32 (c)
module tb_gost89_cfb_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [511:0] sbox;
    logic [255:0] key = 256'hFFEEDDCCBBAA99887766554433221100F0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    logic [63:0] iv = '0;
    logic dec = 1'b0;
    logic ivl_a = 0, vld_a = 1, ordy_a = 1, rdy_a, ov_a, bsy_a;
    logic ivl_b = 0, vld_b = 1, ordy_b = 1, rdy_b, ov_b, bsy_b;
    logic ivl_c = 0, vld_c = 1, ordy_c = 1, rdy_c, ov_c, bsy_c;
    logic [63:0] din_a = '0, od_a;
    logic [7:0]  din_b = '0, od_b;
    logic [31:0] din_c = '0, od_c;
    logic [63:0] q_a[$], q_b[$], q_c[$];
    logic [63:0] gm [3];
    logic [63:0] last;
    logic [7:0]  ct [16];
    logic [767:0] ks_q;
    int checks = 0, errors = 0;
    logic [63:0] srow [8] = '{64'h4A92D80E6B1C7F53, 64'hEB4C6DFA23810759, 64'h581DA342EFC7609B,
                              64'h7DA1089FE46CB253, 64'h6C715FD84A9E03B2, 64'h4BA0721D36859CFE,
                              64'hDB413F590AE7682C, 64'h1FD057A4923E6B8C};
    logic [63:0] iv64 = 64'h0011223344556677, iv8 = 64'hFEDCBA9876543210;

    always #5 clk = ~clk;

    gost89_cfb_stream #(.SEG_W(64)) dut_a (.clk(clk), .reset(reset), .sbox(sbox), .key(key),
        .iv_load(ivl_a), .iv(iv), .decrypt(dec), .in_valid(vld_a), .in_ready(rdy_a), .in_data(din_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .busy(bsy_a));
    gost89_cfb_stream #(.SEG_W(8)) dut_b (.clk(clk), .reset(reset), .sbox(sbox), .key(key),
        .iv_load(ivl_b), .iv(iv), .decrypt(dec), .in_valid(vld_b), .in_ready(rdy_b), .in_data(din_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b), .busy(bsy_b));
    gost89_cfb_stream #(.SEG_W(32)) dut_c (.clk(clk), .reset(reset), .sbox(sbox), .key(key),
        .iv_load(ivl_c), .iv(iv), .decrypt(dec), .in_valid(vld_c), .in_ready(rdy_c), .in_data(din_c),
        .out_valid(ov_c), .out_ready(ordy_c), .out_data(od_c), .busy(bsy_c));

    function automatic logic [31:0] gf(input logic [31:0] x);
        logic [31:0] y = '0;
        for (int j = 0; j < 8; j++) begin
            int nib = int'((x >> (4 * j)) & 32'hF);
            logic [63:0] row = srow[j] >> (4 * (15 - nib));
            y = y | (32'(row[3:0]) << (4 * j));
        end
        return {y[20:0], y[31:21]};
    endfunction

    function automatic logic [63:0] genc(input logic [63:0] x);
        logic [31:0] n1, n2, t, k;
        n1 = x[31:0];
        n2 = x[63:32];
        for (int i = 0; i < 32; i++) begin
            k = 32'(key >> (32 * (i < 24 ? i % 8 : 7 - i % 8)));
            t = n2 ^ gf(n1 + k);
            if (i < 31) begin
                n2 = n1;
                n1 = t;
            end else begin
                n2 = t;
            end
        end
        return {n2, n1};
    endfunction

    function automatic logic rdy(input int s);
        return s == 0 ? rdy_a : s == 1 ? rdy_b : rdy_c;
    endfunction

    function automatic int qsz(input int s);
        return s == 0 ? q_a.size() : s == 1 ? q_b.size() : q_c.size();
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic take(input int s, input logic [63:0] act);
        logic [63:0] e;
        if (qsz(s) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out%0d got %h required no output", s, act);
            return;
        end
        case (s)
            0: e = q_a.pop_front();
            1: e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
        chk($sformatf("out%0d", s), act, e);
    endtask

    always @(negedge clk) begin
        if (ov_a && ordy_a) take(0, od_a);
        if (ov_b && ordy_b) take(1, 64'(od_b));
        if (ov_c && ordy_c) take(2, 64'(od_c));
    end

    always @(posedge clk) begin
        if (bsy_a | bsy_b | bsy_c) assert ({key, sbox} == ks_q) else $error("key or sbox changed while busy");
        ks_q <= {key, sbox};
    end

    task automatic ld(input int s, input logic [63:0] v);
        iv = v;
        case (s) 0: ivl_a = 1; 1: ivl_b = 1; default: ivl_c = 1; endcase
        @(posedge clk);
        #1;
        ivl_a = 0;
        ivl_b = 0;
        ivl_c = 0;
        gm[s] = v;
    endtask

    task automatic send(input int s, input logic [63:0] data, input logic dm, input logic push);
        int n = 0;
        int w = s == 0 ? 64 : s == 1 ? 8 : 32;
        logic [63:0] msk, k, r, cf;
        while (!rdy(s) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy(s)) begin
            checks++;
            errors++;
            $display("FAIL send%0d_timeout in_ready got 0 required 1", s);
            return;
        end
        msk = w == 64 ? '1 : (64'd1 << w) - 64'd1;
        k = genc(gm[s]) >> (64 - w);
        r = (k ^ data) & msk;
        cf = dm ? data & msk : r;
        gm[s] = (gm[s] << w) | cf;
        last = r;
        if (push) case (s) 0: q_a.push_back(r); 1: q_b.push_back(r); default: q_c.push_back(r); endcase
        dec = dm;
        case (s)
            0: begin din_a = data; vld_a = 1; end
            1: begin din_b = data[7:0]; vld_b = 1; end
            default: begin din_c = data[31:0]; vld_c = 1; end
        endcase
        @(posedge clk);
        #1;
        vld_a = 0;
        vld_b = 0;
        vld_c = 0;
    endtask

    task automatic drain(input int s);
        int n = 0;
        while (qsz(s) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (qsz(s) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain%0d_timeout pending got %0d required 0", s, qsz(s));
        end
    endtask

    task automatic wait_ov_b();
        int n = 0;
        while (!ov_b && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_ov_b", 64'(ov_b), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sbox = '0;
        for (int j = 0; j < 8; j++)
            for (int v = 0; v < 16; v++)
                sbox = sbox | (512'(4'(srow[j] >> (60 - 4 * v))) << (64 * j + 4 * v));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_flags_a", 64'({ov_a, rdy_a, bsy_a}), 64'd0);
        chk("rst_flags_b", 64'({ov_b, rdy_b, bsy_b}), 64'd0);
        chk("rst_flags_c", 64'({ov_c, rdy_c, bsy_c}), 64'd0);
        chk("rst_data_a", od_a, 64'd0);
        chk("rst_data_b", 64'(od_b), 64'd0);
        chk("rst_data_c", 64'(od_c), 64'd0);
        @(posedge clk);
        #1;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_accept_b", 64'({rdy_b, bsy_b}), 64'd0);
        chk("idle_no_accept_c", 64'({rdy_c, bsy_c}), 64'd0);
        vld_a = 0;
        vld_b = 0;
        vld_c = 0;

        ld(0, iv64);
        send(0, 64'h0123456789ABCDEF, 0, 1);
        drain(0);
        ld(0, iv64);
        send(0, last, 1, 1);
        drain(0);

        ld(1, iv8);
        for (int i = 0; i < 16; i++) begin
            send(1, 64'(i), 0, 1);
            ct[i] = last[7:0];
            if (i == 0) begin
                drain(1);
                chk("g_after_seg1", dut_b.g, {iv8[55:0], ct[0]});
            end
        end
        drain(1);
        ld(1, iv8);
        for (int i = 0; i < 16; i++) send(1, 64'(ct[i]), 1, 1);
        drain(1);

        ordy_b = 0;
        send(1, 64'hA5, 0, 1);
        wait_ov_b();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_b", 64'({ov_b, rdy_b, bsy_b, od_b}), 64'({3'b101, q_b[0][7:0]}));
        end
        @(posedge clk);
        #1;
        ordy_b = 1;
        @(posedge clk);
        #1;
        chk("release_ov_b", 64'(ov_b), 64'd0);
        chk("release_rdy_b", 64'(rdy_b), 64'd1);

        ld(1, 64'h0F1E2D3C4B5A6978);
        send(1, 64'h3C, 0, 1);
        @(posedge clk);
        #1;
        iv = 64'hDEADBEEFDEADBEEF;
        ivl_b = 1;
        @(posedge clk);
        #1;
        ivl_b = 0;
        drain(1);
        send(1, 64'h3D, 0, 1);
        drain(1);

        ordy_b = 0;
        send(1, 64'h5A, 0, 0);
        wait_ov_b();
        ld(1, 64'h1122334455667788);
        chk("hold_ivload_ov", 64'(ov_b), 64'd0);
        ordy_b = 1;
        send(1, 64'h77, 0, 1);
        drain(1);

        iv = 64'h8877665544332211;
        ivl_b = 1;
        vld_b = 1;
        din_b = 8'h11;
        #1;
        chk("ivload_blocks_ready", 64'(rdy_b), 64'd0);
        @(posedge clk);
        #1;
        ivl_b = 0;
        vld_b = 0;
        gm[1] = iv;
        #1;
        chk("ivload_no_accept", 64'({bsy_b, rdy_b}), 64'd1);
        send(1, 64'h22, 0, 1);
        drain(1);

        ld(2, 64'h0102030405060708);
        send(2, 64'h12345678, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("c_in_run", 64'(bsy_c), 64'd1);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("c_reset_idle", 64'({ov_c, rdy_c, bsy_c}), 64'd0);
        repeat (45) @(posedge clk);
        #1;
        chk("c_after_reset_quiet", 64'({ov_c, rdy_c, bsy_c}), 64'd0);
        ld(2, 64'hA0B1C2D3E4F50617);
        send(2, 64'h12345678, 0, 1);
        send(2, 64'h9ABCDEF0, 0, 1);
        send(2, 64'h0BADF00D, 1, 1);
        drain(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
